// File: rtl/alu_share_arb.sv
// alu_share_arb
//   Shares one combinational ALU among NREQ requesters. Operations are
//   granted round-robin in IDLE. The operands are registered onto the ALU
//   lines for one EXEC cycle. The ALU result is then held in RESP until the
//   owning requester accepts it.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   per-requester op handshake (ready is one-hot or zero)
//   req_sel/req_a/req_b   packed op code / operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready   per-requester result handshake (valid one-hot or zero)
//   rsp_data, rsp_id      captured ALU result and the index of its owner
//   alu_sel/alu_a/alu_b   registered drive to the shared ALU
//   alu_out               combinational ALU result
//   busy                  high while an op is in EXEC or RESP
module alu_share_arb #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32,
  parameter int SELW  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*SELW-1:0]     req_sel,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  output logic [NREQ-1:0]          rsp_valid,
  input  logic [NREQ-1:0]          rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [SELW-1:0]          alu_sel,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  input  logic [WIDTH-1:0]         alu_out,
  output logic                     busy
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [SELW-1:0] ALU_ADD = '0;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] last;       // most recent grant; search starts just above it
  logic [IDW-1:0] owner;      // requester whose op is in flight
  logic [IDW-1:0] grant_idx;
  logic           grant_found;
  logic           accept;
  int             cand;

  // Round-robin search: walk (last+1) .. (last+NREQ) modulo NREQ and take
  // the first valid requester.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last) + k) % NREQ;
      if (!grant_found && req_valid[IDW'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(cand);
      end
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_found && !rst) begin
          req_ready[grant_idx] = 1'b1;
          accept               = 1'b1;
          state_nxt            = S_EXEC;
        end
      end
      S_EXEC: state_nxt = S_RESP;
      S_RESP: if (rsp_ready[owner]) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP) ? (NREQ'(1) << owner) : '0;

  // Datapath: the ALU lines change only on an accept. The result is captured
  // at the end of EXEC, which is the one cycle the ALU sees the new operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      last     <= IDW'(NREQ - 1);
      owner    <= '0;
      alu_sel  <= ALU_ADD;
      alu_a    <= '0;
      alu_b    <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      if (accept) begin
        alu_sel <= req_sel[grant_idx*SELW +: SELW];
        alu_a   <= req_a[grant_idx*WIDTH +: WIDTH];
        alu_b   <= req_b[grant_idx*WIDTH +: WIDTH];
        owner   <= grant_idx;
        last    <= grant_idx;
      end
      if (state == S_EXEC) begin
        rsp_data <= alu_out;
        rsp_id   <= owner;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb
//   Drives alu_share_arb with directed scenarios and then random traffic.
//   The ALU is modelled here. A transaction-level model predicts every
//   output on each falling edge. It tracks which op is in flight, how many
//   cycles have passed since its accept, and the result that op must return.
module tb_alu_share_arb;

  localparam int NREQ  = 2;
  localparam int WIDTH = 32;
  localparam int SELW  = 3;
  localparam int IDW   = $clog2(NREQ);

  localparam logic [SELW-1:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_NOT = 3'd2, OP_LS = 3'd3,
                              OP_RS  = 3'd4, OP_AND = 3'd5, OP_OR  = 3'd6, OP_LT = 3'd7;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NREQ-1:0]         req_valid = '0;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*SELW-1:0]    req_sel = '0;
  logic [NREQ*WIDTH-1:0]   req_a = '0;
  logic [NREQ*WIDTH-1:0]   req_b = '0;
  logic [NREQ-1:0]         rsp_valid;
  logic [NREQ-1:0]         rsp_ready = '1;
  logic [WIDTH-1:0]        rsp_data;
  logic [IDW-1:0]          rsp_id;
  logic [SELW-1:0]         alu_sel;
  logic [WIDTH-1:0]        alu_a, alu_b, alu_out;
  logic                    busy;

  int total = 0;
  int bad   = 0;

  alu_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .SELW(SELW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared ALU behaviour.
  function automatic logic [WIDTH-1:0] alu_fn(logic [SELW-1:0] s, logic [WIDTH-1:0] a,
                                              logic [WIDTH-1:0] b);
    case (s)
      OP_SUB:  return a - b;
      OP_NOT:  return ~a;
      OP_LS:   return a << b;
      OP_RS:   return a >> b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_LT:   return (a < b) ? WIDTH'(1) : WIDTH'(0);
      default: return a + b;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_sel, alu_a, alu_b);

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // First valid requester at or after last+1, wrapping; -1 if none.
  function automatic int rr_pick(logic [NREQ-1:0] v, int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  // ---------------- transaction model ----------------
  bit              chk_en = 0;
  bit              m_busy = 0;
  int              m_last = NREQ - 1;
  int              m_owner = 0;
  int              m_age = 0;          // cycles since accept (1 = EXEC cycle)
  logic [SELW-1:0] m_sel = '0;
  logic [WIDTH-1:0] m_a = '0, m_b = '0, m_exp = '0;
  int              m_wait [NREQ];       // other grants seen while valid (from DUT)

  always @(posedge clk) begin
    automatic logic [NREQ-1:0] acc = req_valid & req_ready;
    automatic int w;
    if (rst) begin
      m_busy = 0; m_last = NREQ - 1; m_sel = '0; m_a = '0; m_b = '0;
      for (int i = 0; i < NREQ; i++) m_wait[i] = 0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) check($sformatf("fair_wait%0d", i), 64'(m_wait[i] <= NREQ - 1), 64'(1));
        if (!req_valid[i] || acc[i]) m_wait[i] = 0;
        else if (acc != '0)          m_wait[i]++;
      end
      if (!m_busy) begin
        w = rr_pick(req_valid, m_last);
        if (w >= 0) begin
          m_busy = 1; m_owner = w; m_age = 1; m_last = w;
          m_sel = req_sel[w*SELW +: SELW];
          m_a   = req_a[w*WIDTH +: WIDTH];
          m_b   = req_b[w*WIDTH +: WIDTH];
          m_exp = alu_fn(m_sel, m_a, m_b);
        end
      end else if (m_age >= 2 && rsp_ready[m_owner]) begin
        m_busy = 0;
      end else begin
        m_age = 2;
      end
    end
    chk_en = 1;
  end

  // Compare process: every falling edge after the first reset edge.
  always @(negedge clk) begin
    if (chk_en) begin
      automatic logic [NREQ-1:0] exp_rdy = '0;
      automatic logic [NREQ-1:0] exp_rv  = '0;
      automatic int w = rr_pick(req_valid, m_last);
      if (!rst && !m_busy && w >= 0) exp_rdy[w] = 1'b1;
      if (m_busy && m_age >= 2) exp_rv[m_owner] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      check("busy",      64'(busy),      64'(m_busy));
      check("alu_sel",   64'(alu_sel),   64'(m_sel));
      check("alu_a",     64'(alu_a),     64'(m_a));
      check("alu_b",     64'(alu_b),     64'(m_b));
      if (m_busy && m_age >= 2) begin
        check("rsp_data", 64'(rsp_data), 64'(m_exp));
        check("rsp_id",   64'(rsp_id),   64'(m_owner));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [SELW-1:0] s, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
    req_valid[i] = 1'b1;
    req_sel[i*SELW +: SELW]   = s;
    req_a[i*WIDTH +: WIDTH]   = a;
    req_b[i*WIDTH +: WIDTH]   = b;
  endtask

  task automatic wait_rsp(input string nm);
    int n = 0;
    #1;
    while (rsp_valid == '0 && n < 20) begin
      tick();
      #1;
      n++;
    end
    check({nm, "_rsp_seen"}, 64'(rsp_valid != '0), 64'(1));
  endtask

  task automatic wait_accept(input int i, input string nm);
    int n = 0;
    #1;
    while (!req_ready[i] && n < 20) begin
      tick();
      #1;
      n++;
    end
    check({nm, "_accept"}, 64'(req_ready[i]), 64'(1));
    tick();
    req_valid[i] = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int gq[$];
    logic [WIDTH-1:0] dq[$];
    int iq[$];
    logic [SELW-1:0] ops[10];
    logic [WIDTH-1:0] oa, ob;
    logic [NREQ-1:0] rdy;

    do_reset();
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_data",  64'(rsp_data),  64'(0));
    check("rst_rsp_id",    64'(rsp_id),    64'(0));
    check("rst_alu_sel",   64'(alu_sel),   64'(OP_ADD));
    check("rst_alu_ab",    64'({alu_a, alu_b}), 64'(0));
    check("rst_busy",      64'(busy),      64'(0));

    // Single op: ADD 5+7 from requester 0.
    set_req(0, OP_ADD, 5, 7);
    #1 check("single_ready", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid[0] = 1'b0;
    #1 check("single_alu_a", 64'(alu_a), 64'(5));
    check("single_alu_b", 64'(alu_b), 64'(7));
    check("single_no_rsp_yet", 64'(rsp_valid), 64'(0));
    tick();
    #1 check("single_rsp_valid", 64'(rsp_valid), 64'(2'b01));
    check("single_rsp_data", 64'(rsp_data), 64'(12));
    check("single_rsp_id", 64'(rsp_id), 64'(0));
    tick();
    tick();

    // Round robin: both requesters valid continuously.
    do_reset();
    set_req(0, OP_SUB, 10, 3);
    set_req(1, OP_LT, 2, 9);
    rsp_ready = '1;
    for (int n = 0; n < 60 && dq.size() < 4; n++) begin
      #1;
      for (int j = 0; j < NREQ; j++) if (req_ready[j]) gq.push_back(j);
      if (rsp_valid != '0) begin
        dq.push_back(rsp_data);
        iq.push_back(int'(rsp_id));
      end
      tick();
    end
    req_valid = '0;
    check("rr_count", 64'(dq.size()), 64'(4));
    for (int i = 0; i < 4 && i < dq.size() && i < gq.size(); i++) begin
      check($sformatf("rr_grant%0d", i), 64'(gq[i]), 64'(i % 2));
      check($sformatf("rr_data%0d", i),  64'(dq[i]), (i % 2) ? 64'(1) : 64'(7));
      check($sformatf("rr_id%0d", i),    64'(iq[i]), 64'(i % 2));
    end
    tick();
    tick();

    // Backpressure with wrong-owner ready; requester 1 waits meanwhile.
    do_reset();
    rsp_ready = 2'b10;
    set_req(0, OP_NOT, 32'h0000FFFF, 0);
    set_req(1, OP_ADD, 1, 1);
    wait_rsp("bp");
    req_valid[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("bp_data",  64'(rsp_data),  64'(32'hFFFF0000));
      check("bp_valid", 64'(rsp_valid), 64'(2'b01));
      check("bp_busy",  64'(busy),      64'(1));
      check("bp_ready", 64'(req_ready), 64'(0));
      tick();
      #1;
    end
    rsp_ready = 2'b01;
    #1 check("bp_hold_until_edge", 64'(rsp_valid), 64'(2'b01));
    tick();
    #1 check("bp_retired", 64'(rsp_valid), 64'(0));
    check("bp_next_grant", 64'(req_ready), 64'(2'b10));
    req_valid = '0;
    rsp_ready = '1;
    tick();

    // Reset in the EXEC cycle of LS 1<<4.
    do_reset();
    set_req(0, OP_LS, 1, 4);
    #1 check("mid_ready", 64'(req_ready), 64'(2'b01));
    tick();
    #1 check("mid_exec_alu", 64'({alu_sel, alu_a, alu_b}), {29'd0, OP_LS, 32'd1, 32'd4} );
    rst = 1'b1;
    #1 check("mid_ready_in_rst", 64'(req_ready), 64'(0));
    tick();
    #1 check("mid_rsp_valid", 64'(rsp_valid), 64'(0));
    check("mid_busy", 64'(busy), 64'(0));
    check("mid_alu", 64'({alu_sel, alu_a, alu_b}), 64'(0));
    check("mid_rsp", 64'({rsp_data, rsp_id}), 64'(0));
    rst = 1'b0;
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1 check("mid_no_rsp", 64'(rsp_valid), 64'(0));
    end
    set_req(1, OP_ADD, 3, 4);
    set_req(0, OP_OR, 3, 4);
    #1 check("mid_first_prio", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid[0] = 1'b0;
    wait_accept(1, "mid_second");
    wait_rsp("mid_second");
    tick();

    // Op sweep through requester NREQ-1, including shifts of 32 or more.
    ops = '{OP_ADD, OP_SUB, OP_NOT, OP_LS, OP_RS, OP_AND, OP_OR, OP_LT, OP_LS, OP_RS};
    for (int k = 0; k < 10; k++) begin
      oa = $urandom;
      ob = (ops[k] == OP_LS || ops[k] == OP_RS) ? WIDTH'($urandom_range(0, 40)) : $urandom;
      if (k >= 8) ob = WIDTH'(32 + k);
      if (ops[k] == OP_LT && k == 7) ob = oa + 1;
      set_req(NREQ - 1, ops[k], oa, ob);
      wait_accept(NREQ - 1, "sweep");
      wait_rsp("sweep");
      check($sformatf("sweep_data%0d", k), 64'(rsp_data), 64'(alu_fn(ops[k], oa, ob)));
      check($sformatf("sweep_id%0d", k), 64'(rsp_id), 64'(NREQ - 1));
      if (k == 7) check("sweep_lt_true", 64'(rsp_data), 64'(oa < ob));
      if (k >= 8) check($sformatf("sweep_wide_shift%0d", k), 64'(rsp_data), 64'(0));
      tick();
    end

    // Random traffic: payload held until accepted, occasional drops and resets.
    req_valid = '0;
    for (int n = 0; n < 600; n++) begin
      rsp_ready = NREQ'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      #1 rdy = req_ready;
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (rdy[i] || (req_valid[i] && $urandom_range(0, 7) == 0)) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          set_req(i, SELW'($urandom), $urandom, WIDTH'($urandom_range(0, 40)));
        end
      end
    end
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    tick();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Arbitrates a single combinational ALU among NREQ requesters, such as the execute stage and a future address/branch unit. It accepts one operation at a time through a valid/ready handshake and drives the ALU select and operand lines from registers. It captures the ALU result and returns it to the winning requester through a valid/ready response channel. The block sits between the requesters and the ALU, and owns the ALU's `alu_sel`, `alu_a` and `alu_b` inputs.

## Interface
- `NREQ`, 2: number of requesters; legal range 2..4.
- `WIDTH`, 32: operand and result width.
- `SELW`, 3: width of the ALU select code; uses the shared ALU op encoding (ALU_ADD, SUB, NOT, LS, RS, AND, OR, LT).
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NREQ: per-requester operation valid.
- `req_ready`  out  NREQ: per-requester accept; one-hot or zero.
- `req_sel`  in  NREQ*SELW: packed op codes; requester i occupies slice [i*SELW +: SELW].
- `req_a`, `req_b`  in  NREQ*WIDTH: packed operands, sliced the same way as `req_sel`.
- `rsp_valid`  out  NREQ: per-requester result valid; one-hot or zero.
- `rsp_ready`  in  NREQ: per-requester result accept.
- `rsp_data`  out  WIDTH: result, shared by all requesters.
- `rsp_id`  out  $clog2(NREQ): index of the requester that owns `rsp_data`.
- `alu_sel`  out  SELW: registered drive to the ALU.
- `alu_a`, `alu_b`  out  WIDTH: registered drive to the ALU.
- `alu_out`  in  WIDTH: combinational ALU result.
- `busy`  out  1: high in EXEC and RESP.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` is high, grant by round-robin: search from index (last+1) mod NREQ upward with wrap-around; the first valid wins.
  - `req_ready[g]` = 1 combinationally for the winner only.
  - On the same edge: latch `req_sel`/`req_a`/`req_b` of g into `alu_sel`/`alu_a`/`alu_b`, set owner=g and last=g, go to EXEC.
- EXEC: the ALU sees the registered operands. At the end of the cycle, capture `alu_out` into `rsp_data`, set `rsp_id`=owner and `rsp_valid[owner]`=1, go to RESP.
- RESP:
  - `rsp_valid[owner]`, `rsp_data` and `rsp_id` are held stable until `rsp_ready[owner]` is 1.
  - On that edge: clear `rsp_valid`, go to IDLE.
  - `rsp_ready` of non-owners is ignored.
- `req_ready` is all-zero in EXEC, RESP, and during any cycle with `rst`=1.
- Requesters must hold `req_valid` and payload stable until accepted. Deasserting before accept is allowed; that requester is then simply not considered.
- Unknown or unused `req_sel` codes are passed through unchanged; the ALU defines their result (its default is ADD).
- No arithmetic is performed in this block. Widths pass through unmodified; `alu_out` is captured bit-exact.
- `alu_sel`/`alu_a`/`alu_b` keep their last values in IDLE and RESP. Nothing updates them except an accept.

## Timing
- Reset values: state=IDLE, last=NREQ-1 (so requester 0 has first priority), `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `alu_sel`=ALU_ADD code, `alu_a`=0, `alu_b`=0, `busy`=0.
- Latency: accept on edge N (valid&&ready). `alu_*` are valid in cycle N+1. `rsp_valid` rises after edge N+1, i.e. visible in cycle N+2.
- With `rsp_ready` held high: the response completes on edge N+2, the next accept can happen on edge N+3, and peak throughput is one op per 3 cycles.
- Fairness: among requesters that hold valid continuously, each waits at most NREQ-1 other operations.
- Simultaneous events:
  - `rsp_ready` for the previous op and a new `req_valid` in the same RESP cycle: the response completes; the new request is granted in the following IDLE cycle, never in RESP.
- Reset mid-operation (`rst`=1 in EXEC or RESP): the in-flight op is discarded, `rsp_valid` drops on that edge, and all registers take their reset values. No response is ever delivered for the discarded op.

## Test plan
- Single op: requester 0 sends ADD, a=5, b=7 → `req_ready[0]`=1 in cycle 0; `alu_a`=5, `alu_b`=7 in cycle 1; `rsp_valid[0]`=1 with `rsp_data`=12 and `rsp_id`=0 in cycle 2.
- Round-robin (NREQ=2), both requesters valid continuously after reset:
  - Requester 0 sends SUB 10-3; requester 1 sends LT 2<9.
  - Grants alternate 0,1,0,1. Results alternate 7 and 1, with `rsp_id` matching the grant each time.
- Backpressure: hold `rsp_ready[0]`=0 for 5 cycles after the result of `NOT a=32'h0000FFFF` → `rsp_data`=32'hFFFF0000 held stable, `busy`=1, and `req_ready`=0 throughout; completes on the cycle ready rises.
- Wrong-owner ready: while requester 0 owns the response, assert `rsp_ready[1]`=1 only → the response is not retired; `rsp_valid[0]` stays 1.
- Reset mid-op: assert `rst` in the EXEC cycle of `LS a=1 b=4` → the next cycle shows all outputs at reset values and no `rsp_valid` pulse; the next request is granted from requester 0 first.
- Full op sweep: run all 8 op codes with random a/b through requester NREQ-1 → each `rsp_data` matches the ALU model exactly, including LT giving 1/0 and shift amounts ≥ 32 giving 0.
